// File: rtl/key_filter.sv
// Debounce filter for one active-low mechanical key.
// Produces press/release pulses, a debounced level and a wrapping press count.
// Optional long-press detection is built when KEY_FILTER_LONG_PRESS_EN is defined;
// without it long_flag is tied low.
module key_filter #(
  parameter logic [19:0] CNT_MAX  = 20'd999_999,
  parameter logic [25:0] LONG_MAX = 26'd49_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_in,
  output logic       key_flag,
  output logic       key_release_flag,
  output logic       key_state,
  output logic       long_flag,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StFiltDn,
    StDown,
    StFiltUp
  } state_e;

  state_e      state;
  logic        key_s1;
  logic        key_s;
  logic [19:0] cnt;
  logic        press_done;

  // Two-flop synchronizer; idles at 1 (released) so reset never looks like a press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_s1 <= 1'b1;
      key_s  <= 1'b1;
    end else begin
      key_s1 <= key_in;
      key_s  <= key_s1;
    end
  end

  // Final filtered sample of a press: the FSM moves to StDown on this edge.
  assign press_done = (state == StFiltDn) && !key_s && (cnt == CNT_MAX);

  // Debounce FSM with registered press/release pulses, level and press count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state            <= StIdle;
      cnt              <= '0;
      key_flag         <= 1'b0;
      key_release_flag <= 1'b0;
      key_state        <= 1'b0;
      press_cnt        <= '0;
    end else begin
      key_flag         <= 1'b0;
      key_release_flag <= 1'b0;
      case (state)
        StIdle: begin
          if (!key_s) begin
            state <= StFiltDn;
            cnt   <= '0;
          end
        end
        StFiltDn: begin
          if (key_s) begin
            state <= StIdle;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state     <= StDown;
            cnt       <= '0;
            key_flag  <= 1'b1;
            key_state <= 1'b1;
            press_cnt <= press_cnt + 8'd1;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        StDown: begin
          if (key_s) begin
            state <= StFiltUp;
            cnt   <= '0;
          end
        end
        StFiltUp: begin
          if (!key_s) begin
            // Release bounce: stay pressed, no pulse.
            state <= StDown;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state            <= StIdle;
            cnt              <= '0;
            key_release_flag <= 1'b1;
            key_state        <= 1'b0;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        default: begin
          state <= StIdle;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_FILTER_LONG_PRESS_EN
  logic [25:0] long_cnt;
  logic        long_done;

  // Hold-time counter: restarts on each debounced press, runs while pressed, fires once.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      long_cnt  <= '0;
      long_done <= 1'b0;
      long_flag <= 1'b0;
    end else begin
      long_flag <= 1'b0;
      if (press_done) begin
        long_cnt  <= '0;
        long_done <= 1'b0;
      end else if ((state == StDown) || (state == StFiltUp)) begin
        if (long_cnt != LONG_MAX) begin
          long_cnt <= long_cnt + 26'd1;
        end else if (!long_done) begin
          long_flag <= 1'b1;
          long_done <= 1'b1;
        end
      end
    end
  end
`else
  // Long-press detection not built.
  assign long_flag = 1'b0;
`endif

endmodule

// File: tb/tb_key_filter.sv
// Self-checking bench for key_filter (CNT_MAX=4, LONG_MAX=20).
// A run-length debounce model is compared against the DUT every cycle; directed
// sequences add literal expectations for latency, bounce, long press and wrap.
module tb_key_filter;

  localparam logic [19:0] CNT_MAX  = 20'd4;
  localparam logic [25:0] LONG_MAX = 26'd20;
  localparam int          CNT_I    = 4;
  localparam int          LONG_I   = 20;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       key_in;
  logic       key_flag;
  logic       key_release_flag;
  logic       key_state;
  logic       long_flag;
  logic [7:0] press_cnt;

  int n_chk;
  int n_err;

  key_filter #(
    .CNT_MAX (CNT_MAX),
    .LONG_MAX(LONG_MAX)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .key_in          (key_in),
    .key_flag        (key_flag),
    .key_release_flag(key_release_flag),
    .key_state       (key_state),
    .long_flag       (long_flag),
    .press_cnt       (press_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: a press/release is accepted once the synchronized key has disagreed with
  // the debounced level for CNT_MAX+2 consecutive edges; long press fires on the
  // (LONG_MAX+1)th edge spent pressed after acceptance.
  logic       m_s1, m_s2, deb;
  int         run, age;
  logic       e_kf, e_rf, e_lf;
  logic [7:0] e_cnt;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_s1  <= 1'b1;
      m_s2  <= 1'b1;
      deb   <= 1'b0;
      run   <= 0;
      age   <= 0;
      e_kf  <= 1'b0;
      e_rf  <= 1'b0;
      e_lf  <= 1'b0;
      e_cnt <= 8'd0;
    end else begin
      m_s1 <= key_in;
      m_s2 <= m_s1;
      e_kf <= 1'b0;
      e_rf <= 1'b0;
      e_lf <= 1'b0;
      if ((!m_s2) != deb) begin
        if (run + 1 == CNT_I + 2) begin
          deb <= ~deb;
          run <= 0;
          if (!deb) begin
            e_kf  <= 1'b1;
            e_cnt <= e_cnt + 8'd1;
            age   <= 0;
          end else begin
            e_rf <= 1'b1;
          end
        end else begin
          run <= run + 1;
        end
      end else begin
        run <= 0;
      end
      if (deb) begin
        age <= age + 1;
`ifdef KEY_FILTER_LONG_PRESS_EN
        if (age + 1 == LONG_I + 1) e_lf <= 1'b1;
`endif
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge sys_clk) begin
    check("m_key_flag", {31'd0, key_flag}, {31'd0, e_kf});
    check("m_release_flag", {31'd0, key_release_flag}, {31'd0, e_rf});
    check("m_key_state", {31'd0, key_state}, {31'd0, deb});
    check("m_long_flag", {31'd0, long_flag}, {31'd0, e_lf});
    check("m_press_cnt", {24'd0, press_cnt}, {24'd0, e_cnt});
  end

  task automatic edges(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_kf"}, {31'd0, key_flag}, 32'd0);
    check({tag, "_rf"}, {31'd0, key_release_flag}, 32'd0);
    check({tag, "_ks"}, {31'd0, key_state}, 32'd0);
    check({tag, "_lf"}, {31'd0, long_flag}, 32'd0);
    check({tag, "_cnt"}, {24'd0, press_cnt}, 32'd0);
  endtask

  int lcount, lpos, rcount, kcount, kpos;

  initial begin
    n_chk     = 0;
    n_err     = 0;
    key_in    = 1'b1;
    sys_rst_n = 1'b0;
    edges(3);
    check_all_zero("reset");
    sys_rst_n = 1'b1;
    edges(5);

    // Clean press: flag in the cycle after edge 8.
    key_in = 1'b0;
    edges(7);
    check("press_pre", {31'd0, key_flag}, 32'd0);
    edges(1);
    check("press_flag", {31'd0, key_flag}, 32'd1);
    check("press_state", {31'd0, key_state}, 32'd1);
    check("press_cnt1", {24'd0, press_cnt}, 32'd1);

    // Long press: hold 40 more cycles.
    lcount = 0;
    lpos   = 0;
    for (int i = 1; i <= 40; i++) begin
      edges(1);
      if (long_flag) begin
        lcount++;
        lpos = i;
      end
    end
`ifdef KEY_FILTER_LONG_PRESS_EN
    check("long_count", lcount, 32'd1);
    check("long_pos", lpos, 32'd21);
`else
    check("long_count", lcount, 32'd0);
`endif

    // Clean release.
    key_in = 1'b1;
    edges(7);
    check("release_pre", {31'd0, key_release_flag}, 32'd0);
    edges(1);
    check("release_flag", {31'd0, key_release_flag}, 32'd1);
    check("release_state", {31'd0, key_state}, 32'd0);
    edges(5);

    // Second press, then a 3-cycle release glitch.
    key_in = 1'b0;
    edges(12);
    check("press_cnt2", {24'd0, press_cnt}, 32'd2);
    key_in = 1'b1;
    edges(3);
    key_in = 1'b0;
    rcount = 0;
    for (int i = 1; i <= 20; i++) begin
      edges(1);
      if (key_release_flag) rcount++;
    end
    check("glitch_rf", rcount, 32'd0);
    check("glitch_state", {31'd0, key_state}, 32'd1);
    key_in = 1'b1;
    edges(12);
    check("glitch_released", {31'd0, key_state}, 32'd0);

    // Bounce on press: low 3, high 2, then low held.
    key_in = 1'b0;
    edges(3);
    key_in = 1'b1;
    edges(2);
    key_in = 1'b0;
    kcount = 0;
    kpos   = 0;
    for (int i = 1; i <= 20; i++) begin
      edges(1);
      if (key_flag) begin
        kcount++;
        kpos = i;
      end
    end
    check("bounce_count", kcount, 32'd1);
    check("bounce_pos", kpos, 32'd8);
    check("bounce_cnt", {24'd0, press_cnt}, 32'd3);
    key_in = 1'b1;
    edges(12);

    // Reset in the middle of press filtering with the key still held.
    key_in = 1'b0;
    edges(5);
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    edges(2);
    check_all_zero("midrst_hold");
    sys_rst_n = 1'b1;
    edges(7);
    check("midrst_pre", {31'd0, key_flag}, 32'd0);
    edges(1);
    check("midrst_flag", {31'd0, key_flag}, 32'd1);
    check("midrst_cnt", {24'd0, press_cnt}, 32'd1);
    key_in = 1'b1;
    edges(12);

    // Press counter wrap.
    sys_rst_n = 1'b0;
    edges(2);
    sys_rst_n = 1'b1;
    edges(2);
    for (int p = 1; p <= 256; p++) begin
      key_in = 1'b0;
      edges(10);
      if (p == 255) check("wrap_255", {24'd0, press_cnt}, 32'd255);
      if (p == 256) check("wrap_256", {24'd0, press_cnt}, 32'd0);
      key_in = 1'b1;
      edges(10);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
